gb_ext_bus_arb: RTL
===================

// Module: gb_ext_bus_arb
// PURPOSE
// - Parametrised arbiter/sequencer for the shared external memory bus (RAM, cartridge, flash).
// - Replaces ad-hoc CPU/DMA/loader muxing with N requesters.
// - Generates timed n_read/n_write strobes, data-bus turnaround and per-master acks.
// - Sits between bus masters (CPU, OAM DMA, prog loader, debugger) and the external pins.
// PARAMETERS
// - NUM_MASTERS  3   number of requesters, 1..8; index 0 = master 0
// - ADR_W        21  external address width
// - DATA_W       8   data width
// - STROBE_CYC   2   cycles n_read/n_write held low per access, 1..15
// - TURN_CYC     1   idle cycles inserted between a read and a following write, 0..3
// - ARB_MODE     0   0 = fixed priority (lowest index wins), 1 = round-robin
// PORTS
// - clk        in   1                   bus clock
// - n_reset    in   1                   asynchronous reset, active low
// - req        in   NUM_MASTERS         access request, level, held until ack
// - wr         in   NUM_MASTERS         1 = write, 0 = read; valid with req
// - lock       in   NUM_MASTERS         keep grant after ack (burst)
// - m_adr      in   NUM_MASTERS*ADR_W   packed addresses; master i at [i*ADR_W +: ADR_W]
// - m_wdata    in   NUM_MASTERS*DATA_W  packed write data
// - gnt        out  NUM_MASTERS         one-hot current owner
// - ack        out  NUM_MASTERS         1-cycle pulse; access complete
// - rdata      out  DATA_W              read data, valid in the ack cycle, held until the next read
// - bus_adr    out  ADR_W               external address
// - bus_dout   out  DATA_W              external write data
// - bus_din    in   DATA_W              external read data
// - bus_oe     out  1                   drive data pins
// - n_read     out  1                   read strobe, active low
// - n_write    out  1                   write strobe, active low
// BEHAVIOUR
// - Reset values: gnt=0, ack=0, rdata=0, bus_adr=0, bus_dout=0, bus_oe=0, n_read=1, n_write=1; state IDLE; RR pointer=0.
// - Asynchronous assertion forces strobes high and oe low immediately; mid-access is aborted, no ack.
// - States: IDLE -> SETUP -> STROBE -> (HOLD | TURN | IDLE).
// - IDLE:
//   - Any req: arbitrate, latch winner's adr/wr/wdata, set gnt, go to SETUP.
//   - No req: gnt=0.
// - SETUP (1 cycle):
//   - bus_adr valid.
//   - bus_oe=1 if write.
//   - Strobes high.
// - STROBE (STROBE_CYC cycles):
//   - n_read or n_write low.
//   - bus_din sampled into rdata on the last cycle.
//   - ack[owner] pulses the cycle after the last strobe cycle.
// - After STROBE:
//   - TURN (TURN_CYC cycles, oe=0) if the access was a read and the next pending winner is a write.
//   - Otherwise HOLD/IDLE.
//   - TURN is skipped when TURN_CYC=0.
// - Latency: req to ack = 1 (arb) + 1 + STROBE_CYC cycles; back-to-back same-direction accesses need no gap beyond IDLE.
// - lock:
//   - If lock[owner]=1 at ack, grant stays; owner's next req goes straight to SETUP without re-arbitration.
//   - Dropping lock releases the grant at the next IDLE.
// - Fixed priority: lowest set req index wins.
// - RR: search starts at pointer; pointer = winner+1 mod NUM_MASTERS after each ack.
// - req dropped mid-access: the access still completes and ack is still pulsed; masters must ignore it.
// - Address/wdata changes after grant are ignored (latched in IDLE).
// - Simultaneous req from all masters in the same cycle: exactly one gnt bit; never more than one gnt bit set.
// STRUCTURE
// - Shared package gb_bus_pkg: state encoding (IDLE/SETUP/STROBE/TURN), ARB_FIXED/ARB_RR constants, helper function onehot_to_idx.
// - One sub-module: gb_rr_pick.
//   - Combinational priority pick with rotating start pointer.
//   - Parametrised on NUM_MASTERS; fixed mode = pointer tied to 0.
// - Top holds the FSM, latches, strobe/turn counters and RR pointer register.
// TESTING
// - Reset: n_reset=0 mid-STROBE of a write.
//   - Same cycle: n_write=1, bus_oe=0, gnt=0.
//   - After release: no ack.
// - Single read, STROBE_CYC=2: master1 reads adr 0x04000, bus_din=0xA5.
//   - n_read low exactly 2 cycles; ack[1] 4 cycles after req.
//   - rdata=0xA5.
// - Fixed priority: req=3'b110 together -> master1 served first, then master2.
//   - With req=3'b111 master0 always wins.
// - Round-robin (ARB_MODE=1): all 3 request continuously.
//   - Grant order 0,1,2,0,1,2.
// - Turnaround (TURN_CYC=2): master0 reads then master2 writes 0x5A.
//   - 2 cycles with bus_oe=0 and both strobes high between accesses.
//   - bus_dout=0x5A during n_write low.
// - Lock: master2 lock=1, 4 writes while master0 requests.
//   - All 4 served to master2 before master0.
//   - Lock dropped -> master0 next.

Source files
------------

// File: rtl/gb_bus_pkg.sv
// Shared definitions for the external bus arbiter: FSM encoding, arbitration modes
// and a one-hot to index helper.
package gb_bus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StTurn
    } bus_state_e;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/gb_rr_pick.sv
// Combinational priority pick: first set request at or after ptr, wrapping around.
// Tie ptr to zero for plain lowest-index-wins priority.
module gb_rr_pick #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] pick,
    output logic                   valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            idx = IDX_W'((32'(ptr) + k) % NUM_MASTERS);
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gb_ext_bus_arb.sv
// Shared external memory bus arbiter/sequencer: picks one master, latches its access,
// and drives timed read/write strobes with optional read-to-write turnaround.
module gb_ext_bus_arb
    import gb_bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned ADR_W       = 21,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned STROBE_CYC  = 2,
    parameter int unsigned TURN_CYC    = 1,
    parameter int unsigned ARB_MODE    = ARB_FIXED
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic [NUM_MASTERS-1:0]        req,
    input  logic [NUM_MASTERS-1:0]        wr,
    input  logic [NUM_MASTERS-1:0]        lock,
    input  logic [NUM_MASTERS*ADR_W-1:0]  m_adr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]        gnt,
    output logic [NUM_MASTERS-1:0]        ack,
    output logic [DATA_W-1:0]             rdata,
    output logic [ADR_W-1:0]              bus_adr,
    output logic [DATA_W-1:0]             bus_dout,
    input  logic [DATA_W-1:0]             bus_din,
    output logic                          bus_oe,
    output logic                          n_read,
    output logic                          n_write
);

    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    bus_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [ADR_W-1:0]       adr_q, adr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   wr_q, wr_d;
    logic                   locked_q, locked_d;
    logic [3:0]             cnt_q, cnt_d;

    logic [NUM_MASTERS-1:0] arb_req, pick;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_ptr, owner_idx, win_idx, next_ptr, sel_idx;
    logic                   start, turn_needed;

    assign owner_idx = IDX_W'(onehot_to_idx(8'(gnt_q)));
    assign win_idx   = IDX_W'(onehot_to_idx(8'(pick)));
    assign next_ptr  = (owner_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_idx + 1'b1;

    // During HOLD the picker looks ahead at who would win next, excluding the current owner.
    assign arb_req  = (state_q == StHold) ? (req & ~gnt_q) : req;
    assign pick_ptr = (ARB_MODE == ARB_RR) ? ((state_q == StHold) ? next_ptr : ptr_q) : '0;

    gb_rr_pick #(
        .NUM_MASTERS(NUM_MASTERS),
        .IDX_W      (IDX_W)
    ) u_pick (
        .req  (arb_req),
        .ptr  (pick_ptr),
        .pick (pick),
        .valid(pick_valid)
    );

    assign turn_needed = lock[owner_idx] ? (req[owner_idx] && wr[owner_idx])
                                         : (pick_valid && wr[win_idx]);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            ptr_q    <= '0;
            adr_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wr_q     <= 1'b0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            adr_q    <= adr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            wr_q     <= wr_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        adr_d    = adr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        wr_d     = wr_q;
        locked_d = locked_q;
        cnt_d    = cnt_q;
        sel_idx  = win_idx;
        start    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (locked_q && lock[owner_idx]) begin
                    // Burst owner keeps the bus and skips arbitration.
                    if (req[owner_idx]) begin
                        start   = 1'b1;
                        sel_idx = owner_idx;
                    end
                end else begin
                    locked_d = 1'b0;
                    gnt_d    = pick;
                    start    = pick_valid;
                end
                if (start) begin
                    adr_d   = m_adr[32'(sel_idx) * ADR_W +: ADR_W];
                    wdata_d = m_wdata[32'(sel_idx) * DATA_W +: DATA_W];
                    wr_d    = wr[sel_idx];
                    cnt_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: state_d = StStrobe;
            StStrobe: begin
                if (cnt_q == 4'(STROBE_CYC - 1)) begin
                    if (!wr_q) rdata_d = bus_din;
                    cnt_d   = '0;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
                ptr_d    = next_ptr;
                locked_d = lock[owner_idx];
                cnt_d    = '0;
                if (!wr_q && (TURN_CYC > 0) && turn_needed) state_d = StTurn;
                else state_d = StIdle;
            end
            StTurn: begin
                if (cnt_q == 4'(TURN_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        n_read  = 1'b1;
        n_write = 1'b1;
        bus_oe  = 1'b0;
        ack     = '0;
        unique case (state_q)
            StSetup:  bus_oe = wr_q;
            StStrobe: begin
                bus_oe  = wr_q;
                n_read  = wr_q;
                n_write = !wr_q;
            end
            StHold:   ack = gnt_q;
            default:  ;
        endcase
    end

    assign gnt      = gnt_q;
    assign rdata    = rdata_q;
    assign bus_adr  = adr_q;
    assign bus_dout = wdata_q;

endmodule
